// File: rtl/aes_decrypt_sequencer.sv
// aes_decrypt_sequencer: iterative AES inverse cipher.
// One inverse round per clock over a single shared datapath.
module aes_decrypt_sequencer #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     data_in,
    input  logic [Nk*32-1:0] key_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     data_out,
    output logic             busy
);
    localparam int NW = 4 * (Nr + 1);
    localparam int SW = 128 * (Nr + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [2047:0] SBOX_P = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] ISBOX_P = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // InvMixColumns coefficients, first row of the circulant matrix
    localparam logic [3:0] MC [4] = '{4'he, 4'hb, 4'hd, 4'h9};

    // Tables are stored entry 0 in the MSBs
    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX_P[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] isb(input logic [7:0] x);
        return ISBOX_P[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by 9, b, d or e (bit 3 is always set)
    function automatic logic [7:0] gm(
        input logic [7:0] x,
        input logic [3:0] c
    );
        logic [7:0] x2, x4, x8;
        x2 = xt(x);
        x4 = xt(x2);
        x8 = xt(x4);
        return x8 ^ (c[2] ? x4 : 8'h00)
                  ^ (c[1] ? x2 : 8'h00)
                  ^ (c[0] ? x  : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    // Full key schedule; slice r is round key r, word 0 in the MSBs
    function automatic logic [SW-1:0] expand(input logic [Nk*32-1:0] key);
        logic [31:0]   w [NW];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [SW-1:0] s;
        rc = 8'h01;
        for (int i = 0; i < Nk; i++) begin
            w[i] = key[32*(Nk-1-i) +: 32];
        end
        for (int i = Nk; i < NW; i++) begin
            t = w[i-1];
            if (i % Nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (Nk > 6 && i % Nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-Nk] ^ t;
        end
        for (int r = 0; r <= Nr; r++) begin
            s[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    function automatic logic [127:0] last_rk(input logic [Nk*32-1:0] key);
        logic [SW-1:0] s;
        s = expand(key);
        return s[128*Nr +: 128];
    endfunction

    // Byte k of the block sits at [127-8k -: 8]; k = row + 4*col
    function automatic logic [127:0] inv_round(
        input logic [127:0] s,
        input logic [127:0] rk,
        input logic         mix
    );
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   m;
        logic [127:0] o;
        for (int k = 0; k < 16; k++) begin
            a[k] = s[127-8*k -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b[r+4*c] = isb(a[r + 4*((c - r + 4) % 4)])
                         ^ rk[127-8*(r+4*c) -: 8];
            end
        end
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                m = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    m = m ^ gm(b[j+4*c], MC[(j - r + 4) % 4]);
                end
                o[127-8*(r+4*c) -: 8] = mix ? m : b[r+4*c];
            end
        end
        return o;
    endfunction

    state_e              state_q, state_d;
    logic [127:0]        st_q, st_d;
    logic [Nk*32-1:0]    key_q, key_d;
    logic [3:0]          rnd_q, rnd_d;
    logic [SW-1:0]       sched;
    logic [127:0]        rk_in;
    logic [127:0]        rk_rnd;
    logic                last;

    assign sched = expand(key_q);
    assign rk_in = last_rk(key_in);
    assign last  = (rnd_q >= 4'(Nr));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign data_out  = out_valid ? st_q : '0;

    // Round-key mux: round r uses slice Nr-r
    always_comb begin
        rk_rnd = '0;
        for (int i = 0; i <= Nr; i++) begin
            if (rnd_q == 4'(Nr - i)) begin
                rk_rnd = sched[128*i +: 128];
            end
        end
    end

    // Next-state logic for the accept / round / present sequence
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    key_d   = key_in;
                    st_d    = data_in ^ rk_in;
                    rnd_d   = 4'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                st_d = inv_round(st_q, rk_rnd, !last);
                if (last) begin
                    state_d = DONE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            st_q    <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
        end
    end

endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// tb_aes_decrypt_sequencer: AES-128/192/256 instances checked
// against known answers and a byte-level inverse-cipher model.
module tb_aes_decrypt_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         iv [3];
    logic         ordy [3];
    logic         rdy [3];
    logic         ov [3];
    logic         bsy [3];
    logic [127:0] dout [3];
    logic [127:0] data_bus;
    logic [255:0] key_bus;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sbx [256];
    logic [7:0] isbx [256];

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] FKEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    aes_decrypt_sequencer #(.Nk(4), .Nr(10)) u128 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(rdy[0]),
        .data_in(data_bus), .key_in(key_bus[255:128]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .data_out(dout[0]), .busy(bsy[0])
    );

    aes_decrypt_sequencer #(.Nk(6), .Nr(12)) u192 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(rdy[1]),
        .data_in(data_bus), .key_in(key_bus[255:64]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .data_out(dout[1]), .busy(bsy[1])
    );

    aes_decrypt_sequencer #(.Nk(8), .Nr(14)) u256 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[2]), .in_ready(rdy[2]),
        .data_in(data_bus), .key_in(key_bus),
        .out_valid(ov[2]), .out_ready(ordy[2]),
        .data_out(dout[2]), .busy(bsy[2])
    );

    function automatic logic [7:0] gmul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbx[t[31:24]], sbx[t[23:16]], sbx[t[15:8]], sbx[t[7:0]]};
    endfunction

    // Textbook inverse cipher on a 16-byte array, column-major
    function automatic logic [127:0] aes_ref(
        input logic [127:0] ct,
        input logic [255:0] key,
        input int           nk
    );
        int           nr;
        logic [31:0]  w [60];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [127:0] res;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int j = 1; j < i/nk; j++) rc = gmul(rc, 8'h02);
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int j = 0; j < 16; j++)
            s[j] = ct[127-8*j -: 8] ^ w[4*nr + j/4][31-8*(j%4) -: 8];
        for (int rnd = nr - 1; rnd >= 0; rnd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    u[r+4*c] = isbx[s[r + 4*((c + 4 - r) % 4)]]
                             ^ w[4*rnd + c][31-8*r -: 8];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c+0] = gmul(u[4*c], 8'h0e) ^ gmul(u[4*c+1], 8'h0b)
                             ^ gmul(u[4*c+2], 8'h0d) ^ gmul(u[4*c+3], 8'h09);
                    s[4*c+1] = gmul(u[4*c], 8'h09) ^ gmul(u[4*c+1], 8'h0e)
                             ^ gmul(u[4*c+2], 8'h0b) ^ gmul(u[4*c+3], 8'h0d);
                    s[4*c+2] = gmul(u[4*c], 8'h0d) ^ gmul(u[4*c+1], 8'h09)
                             ^ gmul(u[4*c+2], 8'h0e) ^ gmul(u[4*c+3], 8'h0b);
                    s[4*c+3] = gmul(u[4*c], 8'h0b) ^ gmul(u[4*c+1], 8'h0d)
                             ^ gmul(u[4*c+2], 8'h09) ^ gmul(u[4*c+3], 8'h0e);
                end
            end else begin
                s = u;
            end
        end
        for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
        return res;
    endfunction

    task automatic chk(
        input string        tag,
        input logic [127:0] obs,
        input logic [127:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One job on instance d; bp = cycles of back-pressure in DONE
    task automatic do_job(
        input int           d,
        input logic [127:0] ct,
        input logic [255:0] k,
        input logic [127:0] exp,
        input int           bp,
        input bit           scramble
    );
        int lat;
        int nr;
        nr = 10 + 2*d;
        @(negedge clk);
        chk("idle_in_ready", rdy[d], 1);
        data_bus = ct;
        key_bus  = k;
        iv[d]    = 1'b1;
        ordy[d]  = (bp == 0);
        @(negedge clk);
        iv[d] = 1'b0;
        if (scramble) begin
            key_bus  = '1;
            data_bus = {$urandom, $urandom, $urandom, $urandom};
        end
        chk("busy_after_accept", bsy[d], 1);
        chk("not_ready_in_round", rdy[d], 0);
        lat = 0;
        while (ov[d] !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 128'(lat), 128'(nr));
        chk("plaintext", dout[d], exp);
        for (int i = 0; i < bp; i++) begin
            iv[d]    = 1'($urandom);
            data_bus = {$urandom, $urandom, $urandom, $urandom};
            key_bus  = {8{$urandom}};
            @(negedge clk);
            chk("bp_out_valid", ov[d], 1);
            chk("bp_data_stable", dout[d], exp);
            chk("bp_in_ready", rdy[d], 0);
        end
        iv[d]   = 1'b0;
        ordy[d] = 1'b1;
        @(negedge clk);
        chk("post_hs_valid", ov[d], 0);
        chk("post_hs_busy", bsy[d], 0);
        chk("post_hs_ready", rdy[d], 1);
        chk("post_hs_data", dout[d], 0);
        @(negedge clk);
        chk("single_hs", ov[d], 0);
        ordy[d] = 1'b0;
    endtask

    initial begin
        logic [127:0] ct;
        logic [255:0] k;
        int           nacc, nout, acc0, acc1, d;
        bit           saw;
        logic [7:0]   inv;

        rst_n    = 1'b0;
        data_bus = '0;
        key_bus  = '0;
        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
        end
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
            sbx[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                   ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbx[sbx[x]] = 8'(x);

        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_valid", ov[i], 0);
            chk("rst_data_out", dout[i], 0);
            chk("rst_busy", bsy[i], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("rst_in_ready", rdy[i], 1);

        do_job(0, CT1, FKEY, PT, 0, 0);
        do_job(1, CT2, FKEY, PT, 0, 0);
        do_job(2, CT3, FKEY, PT, 0, 0);

        do_job(0, CT1, FKEY, PT, 0, 1);
        do_job(0, CT1, FKEY, PT, 20, 1);

        @(negedge clk);
        data_bus = CT1;
        key_bus  = FKEY;
        iv[0]    = 1'b1;
        ordy[0]  = 1'b1;
        nacc = 0;
        nout = 0;
        acc0 = 0;
        acc1 = 0;
        for (int c = 0; c < 40; c++) begin
            if (nacc == 2) iv[0] = 1'b0;
            if (iv[0] && rdy[0]) begin
                if (nacc == 0) acc0 = c;
                else acc1 = c;
                nacc++;
            end
            if (ov[0]) begin
                nout++;
                chk("b2b_data", dout[0], PT);
            end
            @(negedge clk);
        end
        chk("b2b_accepts", 128'(nacc), 2);
        chk("b2b_spacing", 128'(acc1 - acc0), 12);
        chk("b2b_outputs", 128'(nout), 2);
        ordy[0] = 1'b0;

        @(negedge clk);
        data_bus = CT1;
        key_bus  = FKEY;
        iv[0]    = 1'b1;
        ordy[0]  = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_valid", ov[0], 0);
        chk("midrst_data", dout[0], 0);
        chk("midrst_busy", bsy[0], 0);
        chk("midrst_ready", rdy[0], 1);
        saw = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (ov[0]) saw = 1'b1;
        end
        chk("midrst_discard", saw, 0);
        ordy[0] = 1'b0;
        do_job(0, CT1, FKEY, PT, 0, 0);

        for (int n = 0; n < 9; n++) begin
            d  = n % 3;
            ct = {$urandom, $urandom, $urandom, $urandom};
            k  = {8{$urandom}};
            do_job(d, ct, k, aes_ref(ct, k, 4 + 2*d),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
